// File: rtl/direction_ctrl_pkg.sv
// direction_ctrl_pkg
//   Shared definitions for the direction controller: direction state
//   encoding, parameter defaults and the direction transition rule.
//   Optional feature macro (used by direction_ctrl): DIRECTION_CTRL_PAUSE_EN.
package direction_ctrl_pkg;

    typedef enum logic {
        DOWN_DIR = 1'b0,
        UP_DIR   = 1'b1
    } dir_e;

    localparam int DEBOUNCE_CYCLES_DEF = 16;
    localparam int STEP_DIV_DEF        = 8;

    // Simultaneous up/down events cancel; a repeat of the current
    // direction is a no-op, so only a lone opposite event moves the state.
    function automatic dir_e next_dir(input dir_e cur, input logic up_ev, input logic dn_ev);
        next_dir = cur;
        if (up_ev && !dn_ev)
            next_dir = UP_DIR;
        else if (dn_ev && !up_ev)
            next_dir = DOWN_DIR;
    endfunction

endpackage

// File: rtl/debounce.sv
// debounce
//   Two-flop synchronizer, counter-based debouncer and press detector for
//   one raw pushbutton.
// Ports:
//   clock   in  rising-edge clock
//   reset   in  asynchronous active-low reset
//   i_btn   in  raw asynchronous button level (1 = pressed)
//   o_press out one-cycle pulse on each 0->1 change of the debounced level
module debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic i_btn,
    output logic o_press
);

    logic        r_sync1;
    logic        r_sync2;
    logic        r_level;
    logic        r_level_q;
    logic [15:0] r_cnt;
    logic        w_differ;

    assign w_differ = (r_sync2 != r_level);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_q <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= i_btn;
            r_sync2   <= r_sync1;
            r_level_q <= r_level;
            if (!w_differ) begin
                r_cnt <= '0;
            end else if (r_cnt == 16'(DEBOUNCE_CYCLES - 1)) begin
                // This mismatch is the DEBOUNCE_CYCLES-th in a row: accept it.
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    // Rising edge of the debounced level only; releases are silent.
    assign o_press = r_level & ~r_level_q;

endmodule

// File: rtl/direction_ctrl.sv
// direction_ctrl
//   Turns two pushbuttons into a direction level for a light sequencer,
//   plus a free-running step tick.
//   Optional feature: define DIRECTION_CTRL_PAUSE_EN to let a simultaneous
//   press of both buttons toggle a pause that freezes the step prescaler.
// Ports:
//   clock       in  rising-edge clock
//   reset       in  asynchronous active-low reset
//   btn_up      in  raw button, 1 = pressed
//   btn_down    in  raw button, 1 = pressed
//   up          out registered direction (1 = count up)
//   step        out registered one-cycle advance tick
//   dir_changed out registered one-cycle pulse when up changes
//   paused      out registered pause flag (0 when the feature is off)
module direction_ctrl
    import direction_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int STEP_DIV        = STEP_DIV_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_up,
    input  logic btn_down,
    output logic up,
    output logic step,
    output logic dir_changed,
    output logic paused
);

    logic        w_up_press;
    logic        w_dn_press;
    dir_e        r_state;
    dir_e        w_state_nxt;
    logic        r_dir_changed;
    logic [15:0] r_pre_cnt;
    logic        r_step;
    logic        w_run;

    debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
        .clock   (clock),
        .reset   (reset),
        .i_btn   (btn_up),
        .o_press (w_up_press)
    );

    debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_dn (
        .clock   (clock),
        .reset   (reset),
        .i_btn   (btn_down),
        .o_press (w_dn_press)
    );

    // Direction FSM
    always_comb begin
        w_state_nxt = r_state;
        w_state_nxt = next_dir(r_state, w_up_press, w_dn_press);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= UP_DIR;
            r_dir_changed <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            // Registered alongside the state so the pulse lines up with
            // the first cycle that shows the new direction.
            r_dir_changed <= (w_state_nxt != r_state);
        end
    end

`ifdef DIRECTION_CTRL_PAUSE_EN
    logic r_paused;
    logic w_both;

    assign w_both = w_up_press & w_dn_press;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_paused <= 1'b0;
        else if (w_both)
            r_paused <= ~r_paused;
    end

    assign w_run  = ~r_paused;
    assign paused = r_paused;
`else
    assign w_run  = 1'b1;
    assign paused = 1'b0;
`endif

    // Step prescaler: free-running, unaffected by direction changes;
    // while paused it holds its count so the phase resumes unchanged.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pre_cnt <= '0;
            r_step    <= 1'b0;
        end else begin
            r_step <= w_run && (r_pre_cnt == 16'(STEP_DIV - 1));
            if (w_run) begin
                if (r_pre_cnt == 16'(STEP_DIV - 1))
                    r_pre_cnt <= '0;
                else
                    r_pre_cnt <= r_pre_cnt + 16'd1;
            end
        end
    end

    assign up          = (r_state == UP_DIR);
    assign step        = r_step;
    assign dir_changed = r_dir_changed;

endmodule

// File: tb/tb_direction_ctrl.sv
// tb_direction_ctrl
//   Directed scenarios followed by random button activity, every cycle
//   compared against an edge-indexed reference model of the button rules.
module tb_direction_ctrl;

    localparam int D   = 4;
    localparam int DIV = 3;
`ifdef DIRECTION_CTRL_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    logic clock    = 1'b0;
    logic reset    = 1'b0;
    logic btn_up   = 1'b0;
    logic btn_down = 1'b0;
    logic up, step, dir_changed, paused;

    int n_vec = 0;
    int n_err = 0;

    direction_ctrl #(.DEBOUNCE_CYCLES(D), .STEP_DIV(DIV)) dut (
        .clock       (clock),
        .reset       (reset),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .up          (up),
        .step        (step),
        .dir_changed (dir_changed),
        .paused      (paused)
    );

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    // Edges are numbered from 1 after reset release. m_hist_x[k+1] holds
    // the raw level sampled at edge k; entries for k=-1,0 are the reset
    // zeros in the synchronizer. The debounce logic at edge k sees the
    // sample from edge k-2.
    bit m_hist_u[$];
    bit m_hist_d[$];
    bit m_deb_u, m_deb_d;
    int m_acc_u, m_acc_d;      // edge of last accepted change (0 = reset)
    bit m_ev_u, m_ev_d;        // press events visible before the next edge
    int m_k;
    int m_run;                 // edges on which the prescaler advanced
    bit m_up, m_chg, m_step, m_paused;

    task automatic model_reset();
        m_hist_u.delete();
        m_hist_d.delete();
        m_hist_u.push_back(1'b0); m_hist_u.push_back(1'b0);
        m_hist_d.push_back(1'b0); m_hist_d.push_back(1'b0);
        m_deb_u = 0; m_deb_d = 0;
        m_acc_u = 0; m_acc_d = 0;
        m_ev_u = 0; m_ev_d = 0;
        m_k = 0; m_run = 0;
        m_up = 1; m_chg = 0; m_step = 0; m_paused = 0;
    endtask

    // A new level is accepted once the last D seen samples all disagree
    // with the debounced level and none of them predate the last accept.
    function automatic bit accept(input bit is_up, input bit deb, input int acc);
        bit s;
        if (m_k - acc < D) return 1'b0;
        for (int i = 0; i < D; i++) begin
            s = is_up ? m_hist_u[m_k - 1 - i] : m_hist_d[m_k - 1 - i];
            if (s == deb) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_edge(input bit u_raw, input bit d_raw);
        bit a_u, a_d;
        m_k++;
        m_chg = 0;
        if (m_ev_u && !m_ev_d && !m_up) begin
            m_up = 1; m_chg = 1;
        end else if (m_ev_d && !m_ev_u && m_up) begin
            m_up = 0; m_chg = 1;
        end
        if (!m_paused) begin
            m_run++;
            m_step = (m_run % DIV == 0);
        end else begin
            m_step = 0;
        end
        if (PAUSE_EN && m_ev_u && m_ev_d) m_paused = !m_paused;
        m_hist_u.push_back(u_raw);
        m_hist_d.push_back(d_raw);
        a_u = accept(1'b1, m_deb_u, m_acc_u);
        a_d = accept(1'b0, m_deb_d, m_acc_d);
        m_ev_u = 0; m_ev_d = 0;
        if (a_u) begin m_deb_u = !m_deb_u; m_acc_u = m_k; m_ev_u = m_deb_u; end
        if (a_d) begin m_deb_d = !m_deb_d; m_acc_d = m_k; m_ev_d = m_deb_d; end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic obs, input bit exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0b expected %0b (edge %0d)", tag, obs, exp, m_k);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("up", up, m_up);
        chk("step", step, m_step);
        chk("dir_changed", dir_changed, m_chg);
        chk("paused", paused, m_paused);
    endtask

    task automatic tick(input logic u, input logic d);
        btn_up   = u;
        btn_down = d;
        @(posedge clock);
        model_edge(u, d);
        #1;
        check_all();
    endtask

    // Called 1 time unit after a rising edge; leaves reset released mid-cycle.
    task automatic do_reset();
        btn_up   = 1'b0;
        btn_down = 1'b0;
        reset    = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clock);
        #1;
        check_all();
        reset = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int dc_cnt;
        bit saw_dc;
        logic u, d;
        int len;

        @(posedge clock);
        #1;
        do_reset();

        // Reset release: step at edge 3, 6, 9
        repeat (9) tick(0, 0);

        // 3-cycle glitch on btn_down: rejected
        saw_dc = 0;
        repeat (3) begin tick(0, 1); saw_dc |= dir_changed; end
        repeat (10) begin tick(0, 0); saw_dc |= dir_changed; end
        chk("glitch_no_dc", saw_dc, 1'b0);
        chk("glitch_up", up, 1'b1);

        // btn_up while already up: no change
        saw_dc = 0;
        repeat (8) begin tick(1, 0); saw_dc |= dir_changed; end
        repeat (4) begin tick(0, 0); saw_dc |= dir_changed; end
        chk("upbtn_no_dc", saw_dc, 1'b0);
        chk("upbtn_up", up, 1'b1);

        // btn_down held 10 cycles: up falls D+3 edges after first sample
        lat = 0; dc_cnt = 0;
        for (int t = 1; t <= 10; t++) begin
            tick(0, 1);
            if (lat == 0 && up === 1'b0) lat = t;
            if (dir_changed === 1'b1) dc_cnt++;
        end
        repeat (5) begin tick(0, 0); if (dir_changed === 1'b1) dc_cnt++; end
        chk_int("down_latency", lat, D + 3);
        chk_int("down_dc_pulses", dc_cnt, 1);
        chk("down_up", up, 1'b0);

        // back to up
        repeat (8) tick(1, 0);
        repeat (4) tick(0, 0);
        chk("back_up", up, 1'b1);

        // both buttons together: no direction change, pause toggles if enabled
        repeat (10) tick(1, 1);
        chk("both_up", up, 1'b1);
        chk("both_paused", paused, PAUSE_EN);
        repeat (6) tick(0, 0);
        repeat (10) tick(1, 1);
        chk("both2_paused", paused, 1'b0);
        repeat (8) tick(0, 0);

        // reset during a 2-cycle-old debounce discards it
        repeat (4) tick(0, 1);
        do_reset();
        repeat (15) tick(0, 0);
        chk("rst_mid_up", up, 1'b1);

        // random button activity
        for (int s = 0; s < 60; s++) begin
            u   = 1'($urandom_range(0, 1));
            d   = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 10));
            for (int c = 0; c < len; c++) tick(u, d);
            if (s == 30) do_reset();
        end
        repeat (10) tick(0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/direction_ctrl.md
DIRECTION_CTRL -- requirements
Module: direction_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, the number of consecutive cycles a synchronized button level must differ from its debounced level before it is accepted (legal range 1..65535).
REQ-002 SHALL have parameter STEP_DIV, default 8, the cycle period of the step tick (legal range 2..65535).
REQ-003 SHALL have port clock, input, 1 bit, the single clock; all flops are rising-edge triggered.
REQ-004 SHALL have port reset, input, 1 bit, an asynchronous, active-low reset.
REQ-005 SHALL have port btn_up, input, 1 bit, a raw asynchronous pushbutton where 1 means pressed.
REQ-006 SHALL have port btn_down, input, 1 bit, a raw asynchronous pushbutton where 1 means pressed.
REQ-007 SHALL have port up, output, 1 bit, the registered direction level feeding the downstream light sequencer, where 1 means count up.
REQ-008 SHALL have port step, output, 1 bit, a registered one-cycle advance tick.
REQ-009 SHALL have port dir_changed, output, 1 bit, a registered one-cycle pulse on each change of up.
REQ-010 SHALL have port paused, output, 1 bit, the registered pause flag.

Function
REQ-011 SHALL pass each button through its own two-flop synchronizer.
REQ-012 SHALL keep a counter and a debounced level per button:
- counter increments while the synchronized level differs from the debounced level;
- counter clears to 0 the cycle the levels match;
- when the count reaches DEBOUNCE_CYCLES, the debounced level takes the new value and the counter clears.
REQ-013 SHALL generate a one-cycle press event for each 0->1 transition of a debounced level; releases generate no event.
REQ-014 SHALL implement a two-state direction FSM, UP_DIR (up=1) and DOWN_DIR (up=0):
- down event in UP_DIR -> DOWN_DIR;
- up event in DOWN_DIR -> UP_DIR;
- up event in UP_DIR, or down event in DOWN_DIR -> no change.
REQ-015 SHALL treat up and down events in the same cycle as neither event; see REQ-021 for pause behaviour.
REQ-016 SHALL assert dir_changed for exactly the cycle after the state register changes.
REQ-017 SHALL make up change exactly DEBOUNCE_CYCLES+3 rising edges after the first edge that samples the new stable raw level.
REQ-018 SHALL run the prescaler as a counter counting 0..STEP_DIV-1 and wrapping to 0; step=1 only in the cycle after the counter equals STEP_DIV-1.
REQ-019 SHALL keep prescaler phase independent of direction changes, with no restart on dir_changed.

Reset
REQ-020 SHALL, while reset=0, immediately force the following, with the FSM in UP_DIR:
- up=1, step=0, dir_changed=0, paused=0;
- all synchronizer flops, debounced levels and counters to 0.

Reset asserted mid-debounce or mid-prescale SHALL discard partial counts. First step SHALL occur STEP_DIV cycles after reset release.

Configuration
REQ-021 SHALL, when macro DIRECTION_CTRL_PAUSE_EN is defined:
- toggle paused on each cycle with simultaneous up and down events;
- while paused=1, hold the prescaler counter and force step=0;
- on un-pause, resume the prescaler from the held count.
REQ-022 SHALL, when DIRECTION_CTRL_PAUSE_EN is undefined, tie paused to 0, never suppress step, and ignore simultaneous events entirely.

Structure
REQ-023 SHALL place the direction state encoding (UP_DIR=1, DOWN_DIR=0) and the parameter default constants in the shared package direction_ctrl_pkg.
REQ-024 SHALL implement synchronizer plus debounce plus press-event detection as sub-module debounce, instantiated twice.

Verification
REQ-025 SHALL cover these directed scenarios, each with DEBOUNCE_CYCLES=4 and STEP_DIV=3:
- Reset release -> up=1; step first high at cycle 3 after release, then every 3 cycles.
- btn_down held 10 cycles -> up falls exactly 7 edges after first sample; dir_changed high for 1 cycle.
- btn_down glitch 3 cycles high then low -> up stays 1; dir_changed never asserted.
- btn_up pressed while up=1 -> no change and no dir_changed; then btn_down -> up=0.
- Both buttons rise in the same cycle and are held -> up unchanged. With DIRECTION_CTRL_PAUSE_EN: paused=1 and step stays 0. Repeat press -> paused=0 and step resumes with the held phase.
- reset pulsed low during a 2-cycle-old debounce -> no direction change after release; outputs return to reset values.
